vpa_sync_cycle: RTL and testbench
=================================

# vpa_sync_cycle

Completes 6800-style synchronous bus cycles for the PiStorm16 68000 bus master. It sits directly downstream of the Pi access state machine. When the addressed peripheral answers with nVPA instead of nDTACK, the access FSM hands the cycle to this block. The block tracks E-clock phase from 7 MHz falling-edge strobes, drives VMA in the correct E window, latches read data before E falls, and signals completion so the access FSM can negate AS/DS.

## Interface
Parameters:
- E_PERIOD, 10: 7M falling edges per E period.
- E_HIGH_START, 6: ecnt value at which E goes high. E is low for ecnt 0..5 and high for ecnt 6..9.
- VMA_SLOT, 2: last ecnt value at which VMA may be asserted for the current period.

Ports:
- SYSCLK in 1: system clock from PLL. Sole clock.
- nRESET in 1: reset, asynchronous, active-low.
- MCCLK_FALLING in 1: one-SYSCLK pulse per CLK_7M falling edge, from ClockSync.
- ECLK in 1: E clock from EClock generator, async to SYSCLK.
- nVPA in 1: raw Amiga nVPA.
- START in 1: pulse from access FSM; AS is asserted and the cycle is waiting for termination.
- IS_READ in 1: direction of the pending cycle. Sampled on START.
- D_IN in 16: synchronized data bus (din_sync[1]).
- RELEASE in 1: level; access FSM has negated AS/DS.
- ABORT in 1: pulse; bus error or reset abort.
- VMA_DRIVE out 1: drive nVMA low (feeds nVMA_OE).
- BUSY out 1: block owns the cycle.
- DONE out 1: one-cycle pulse; cycle complete, AS/DS may be negated.
- DATA_OUT out 16: latched read data. Valid from DONE until the next START.
- ECNT out 4: current E phase counter (debug/status).

## Operation
- **Sync:** ECLK and nVPA each pass through a 2-FF synchronizer with async_reg. ECLK is then sampled only when MCCLK_FALLING is high, into e_prev.
- **Phase counter ecnt (0..E_PERIOD-1):** advances on every MCCLK_FALLING and wraps from E_PERIOD-1 to 0. When a sampled ECLK rising transition (e_prev=0, sample=1) occurs, ecnt is forced to E_HIGH_START instead of incrementing. This resync takes priority over wrap. ecnt runs regardless of FSM state.
- **States:** IDLE, ARM, WAIT_VMA, VMA_ON, LATCH, DONE_ST, HOLD.
  - IDLE: on START, capture IS_READ and go to ARM. BUSY=1 from the next cycle.
  - ARM: if synced nVPA=1, go to IDLE. This is a DTACK cycle, not ours; no DONE. Otherwise go to WAIT_VMA.
  - WAIT_VMA: on MCCLK_FALLING with ecnt==VMA_SLOT (pre-increment value), set VMA_DRIVE=1 and go to VMA_ON. If START arrives later in the period, wait for the next period.
  - VMA_ON: on MCCLK_FALLING with ecnt==E_PERIOD-1 (last E-high edge), go to LATCH.
  - LATCH: if read, DATA_OUT <= D_IN. Go to DONE_ST in the same cycle.
  - DONE_ST: on MCCLK_FALLING with ecnt==0 (E has fallen), pulse DONE for one cycle and go to HOLD.
  - HOLD: keep VMA_DRIVE=1 until RELEASE=1, then clear VMA_DRIVE, clear BUSY, and go to IDLE.
- **Write cycles:** follow the same path. DATA_OUT is unchanged.
- **ABORT:** from any state, ABORT goes to IDLE with VMA_DRIVE=0 and BUSY=0, and DONE is not pulsed. ABORT has priority over every transition in the same cycle.
- **START while BUSY:** ignored.

## Timing
- **Reset values:** state=IDLE, ecnt=0, VMA_DRIVE=0, BUSY=0, DONE=0, DATA_OUT=0, ECNT=0, and all synchronizers=0.
- **nVPA latency:** 2 SYSCLK synchronizer delay. ARM samples nVPA 1 cycle after START.
- **VMA assertion:** VMA_DRIVE rises 1 SYSCLK after the qualifying MCCLK_FALLING pulse.
- **Read data:** D_IN is captured 1 SYSCLK after the ecnt==9 pulse, which lies inside E high.
- **DONE:** asserted 1 SYSCLK after the ecnt==0 pulse, for 1 cycle only.
- **Cycle length:** from START to DONE is 1 to 2 E periods, depending on the phase at START.
- **VMA release:** VMA_DRIVE falls 1 SYSCLK after RELEASE is seen high in HOLD.

## Test plan
- **Read, well-aligned:** START with nVPA=0, IS_READ=1, D_IN=16'hA5C3, issued at ecnt=0. Expect VMA rising after the ecnt=2 pulse, DATA_OUT=16'hA5C3 after ecnt=9, and DONE at the next ecnt=0. With RELEASE=1, VMA drops and BUSY=0.
- **Late START:** START issued at ecnt=4. Expect VMA not asserted until ecnt=2 of the next period, and DONE 10 7M falls after that period's start.
- **DTACK cycle:** START with nVPA=1. Expect return to IDLE within 2 cycles, with VMA_DRIVE=0 and no DONE pulse.
- **Write:** IS_READ=0 with DATA_OUT preloaded to 16'h1234. Expect DONE to occur and DATA_OUT to remain 16'h1234.
- **ABORT in VMA_ON:** expect VMA_DRIVE=0 and BUSY=0 on the next cycle, and no DONE. A following START completes normally.
- **Resync and reset:** drive an ECLK rising edge while ecnt=3. Expect ecnt=6 on that pulse. Assert nRESET mid-HOLD: expect all outputs to return to their reset values asynchronously.

Source files
------------

// File: rtl/vpa_sync_cycle.sv
// -----------------------------------------------------------------------------
// vpa_sync_cycle
//
// Completes 6800-style synchronous (nVPA-terminated) bus cycles on behalf of
// the Pi access state machine. Once the access FSM has asserted AS and hands
// the cycle over with START, this block:
//   - tracks the E-clock phase (ecnt) from CLK_7M falling-edge strobes,
//     resynchronising on every sampled rising edge of ECLK,
//   - drops the cycle again when the peripheral answered with DTACK
//     (nVPA still high),
//   - asserts VMA in the allowed slot of the E period,
//   - captures read data on the last 7M falling edge of E high,
//   - pulses DONE once E has fallen, so AS/DS may be negated,
//   - holds VMA until the access FSM reports RELEASE.
//
// Ports
//   SYSCLK        in   system clock (sole clock)
//   nRESET        in   asynchronous active-low reset
//   MCCLK_FALLING in   one-SYSCLK strobe per CLK_7M falling edge
//   ECLK          in   E clock, asynchronous to SYSCLK
//   nVPA          in   raw Amiga nVPA, asynchronous to SYSCLK
//   START         in   pulse: AS asserted, cycle awaiting termination
//   IS_READ       in   direction of the pending cycle, sampled on START
//   D_IN[15:0]    in   synchronised data bus
//   RELEASE       in   level: access FSM has negated AS/DS
//   ABORT         in   pulse: bus error / reset abort
//   VMA_DRIVE     out  drive nVMA low
//   BUSY          out  block owns the cycle
//   DONE          out  one-cycle pulse: cycle complete
//   DATA_OUT[15:0]out  latched read data, valid from DONE until next START
//   ECNT[3:0]     out  current E phase counter
// -----------------------------------------------------------------------------
module vpa_sync_cycle #(
  parameter int E_PERIOD     = 10,
  parameter int E_HIGH_START = 6,
  parameter int VMA_SLOT     = 2
) (
  input  logic        SYSCLK,
  input  logic        nRESET,
  input  logic        MCCLK_FALLING,
  input  logic        ECLK,
  input  logic        nVPA,
  input  logic        START,
  input  logic        IS_READ,
  input  logic [15:0] D_IN,
  input  logic        RELEASE,
  input  logic        ABORT,
  output logic        VMA_DRIVE,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] DATA_OUT,
  output logic [3:0]  ECNT
);

  // Phase counter landmarks, pre-increment values seen on a 7M falling strobe.
  localparam logic [3:0] ECNT_LAST  = 4'(E_PERIOD - 1);   // last E-high edge
  localparam logic [3:0] ECNT_HIGH  = 4'(E_HIGH_START);   // E rising
  localparam logic [3:0] ECNT_VMA   = 4'(VMA_SLOT);       // last VMA slot
  localparam logic [3:0] ECNT_EFALL = 4'd0;               // E has fallen

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_VMA = 3'd2,
    ST_VMA_ON   = 3'd3,
    ST_LATCH    = 3'd4,
    ST_DONE     = 3'd5,
    ST_HOLD     = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and phase tracking
  // ---------------------------------------------------------------------------
  (* async_reg = "true" *) logic eclk_meta_r;
  (* async_reg = "true" *) logic eclk_sync_r;
  (* async_reg = "true" *) logic nvpa_meta_r;
  (* async_reg = "true" *) logic nvpa_sync_r;

  logic       e_prev_r;
  logic       e_prev_next_s;
  logic [3:0] ecnt_r;
  logic [3:0] ecnt_next_s;
  logic       e_rise_s;

  // Next phase value for one 7M falling edge; an E rising edge re-aligns the
  // counter to the start of E high and wins over the normal wrap.
  function automatic logic [3:0] ecnt_step(input logic [3:0] cur,
                                           input logic       rise);
    logic [3:0] nxt;
    if (rise) begin
      nxt = ECNT_HIGH;
    end else if (cur == ECNT_LAST) begin
      nxt = 4'd0;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

  // Two-flop synchronisers for the asynchronous ECLK and nVPA inputs.
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      eclk_meta_r <= 1'b0;
      eclk_sync_r <= 1'b0;
      nvpa_meta_r <= 1'b0;
      nvpa_sync_r <= 1'b0;
    end else begin
      eclk_meta_r <= ECLK;
      eclk_sync_r <= eclk_meta_r;
      nvpa_meta_r <= nVPA;
      nvpa_sync_r <= nvpa_meta_r;
    end
  end

  // E is only looked at on 7M falling strobes, so a rise is detected between
  // two consecutive strobe samples.
  assign e_rise_s = ~e_prev_r & eclk_sync_r;

  // Phase counter and ECLK strobe sample next-state; both run in every state.
  always_comb begin
    e_prev_next_s = e_prev_r;
    ecnt_next_s   = ecnt_r;
    if (MCCLK_FALLING) begin
      e_prev_next_s = eclk_sync_r;
      ecnt_next_s   = ecnt_step(ecnt_r, e_rise_s);
    end else begin
      e_prev_next_s = e_prev_r;
      ecnt_next_s   = ecnt_r;
    end
  end

  // Phase counter and ECLK strobe sample registers.
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      e_prev_r <= 1'b0;
      ecnt_r   <= 4'd0;
    end else begin
      e_prev_r <= e_prev_next_s;
      ecnt_r   <= ecnt_next_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle FSM
  // ---------------------------------------------------------------------------
  state_t      state_r;
  state_t      state_next_s;
  logic        is_read_r;
  logic        is_read_next_s;
  logic        vma_r;
  logic        vma_next_s;
  logic        busy_r;
  logic        busy_next_s;
  logic        done_r;
  logic        done_next_s;
  logic [15:0] data_r;
  logic [15:0] data_next_s;

  // Strobe-qualified phase decodes used by the FSM (pre-increment phase).
  logic slot_vma_s;
  logic slot_last_s;
  logic slot_efall_s;

  assign slot_vma_s   = MCCLK_FALLING & (ecnt_r == ECNT_VMA);
  assign slot_last_s  = MCCLK_FALLING & (ecnt_r == ECNT_LAST);
  assign slot_efall_s = MCCLK_FALLING & (ecnt_r == ECNT_EFALL);

  // Next-state and registered-output values for the cycle FSM.
  always_comb begin
    state_next_s   = state_r;
    is_read_next_s = is_read_r;
    vma_next_s     = vma_r;
    busy_next_s    = busy_r;
    done_next_s    = 1'b0;
    data_next_s    = data_r;

    if (ABORT) begin
      // Abort wins over everything, including a START in the same cycle.
      state_next_s = ST_IDLE;
      vma_next_s   = 1'b0;
      busy_next_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            is_read_next_s = IS_READ;
            busy_next_s    = 1'b1;
            state_next_s   = ST_ARM;
          end else begin
            state_next_s = ST_IDLE;
          end
        end

        ST_ARM: begin
          // nVPA still high means the peripheral used DTACK: hand back silently.
          if (nvpa_sync_r) begin
            busy_next_s  = 1'b0;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_VMA;
          end
        end

        ST_WAIT_VMA: begin
          // Missing the slot simply defers VMA to the next E period.
          if (slot_vma_s) begin
            vma_next_s   = 1'b1;
            state_next_s = ST_VMA_ON;
          end else begin
            state_next_s = ST_WAIT_VMA;
          end
        end

        ST_VMA_ON: begin
          if (slot_last_s) begin
            state_next_s = ST_LATCH;
          end else begin
            state_next_s = ST_VMA_ON;
          end
        end

        ST_LATCH: begin
          if (is_read_r) begin
            data_next_s = D_IN;
          end else begin
            data_next_s = data_r;
          end
          state_next_s = ST_DONE;
        end

        ST_DONE: begin
          if (slot_efall_s) begin
            done_next_s  = 1'b1;
            state_next_s = ST_HOLD;
          end else begin
            state_next_s = ST_DONE;
          end
        end

        ST_HOLD: begin
          if (RELEASE) begin
            vma_next_s   = 1'b0;
            busy_next_s  = 1'b0;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_HOLD;
          end
        end

        default: begin
          state_next_s = ST_IDLE;
          vma_next_s   = 1'b0;
          busy_next_s  = 1'b0;
        end
      endcase
    end
  end

  // Cycle FSM state and registered outputs.
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r   <= ST_IDLE;
      is_read_r <= 1'b0;
      vma_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      data_r    <= 16'h0000;
    end else begin
      state_r   <= state_next_s;
      is_read_r <= is_read_next_s;
      vma_r     <= vma_next_s;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
      data_r    <= data_next_s;
    end
  end

  assign VMA_DRIVE = vma_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign DATA_OUT  = data_r;
  assign ECNT      = ecnt_r;

endmodule

// File: tb/tb_vpa_sync_cycle.sv
// -----------------------------------------------------------------------------
// tb_vpa_sync_cycle
//
// Drives vpa_sync_cycle with a 7M strobe every 4 SYSCLK cycles. The expected
// E phase is derived arithmetically from a reference strobe (p0 = a strobe
// cycle, e0 = the phase seen on that strobe), and the expected VMA, capture
// and DONE cycles of each transaction are found by searching that arithmetic
// phase sequence for the landmarks 2, 9 and 0.
// Cycle numbering: "cycle c" is the SYSCLK period that follows the c-th
// rising edge; outputs are read and inputs driven 1 time unit into it.
// -----------------------------------------------------------------------------
module tb_vpa_sync_cycle;

  logic        SYSCLK;
  logic        nRESET;
  logic        MCCLK_FALLING;
  logic        ECLK;
  logic        nVPA;
  logic        START;
  logic        IS_READ;
  logic [15:0] D_IN;
  logic        RELEASE;
  logic        ABORT;
  logic        VMA_DRIVE;
  logic        BUSY;
  logic        DONE;
  logic [15:0] DATA_OUT;
  logic [3:0]  ECNT;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int p0     = 0;
  int e0     = 0;
  logic [15:0] m_data = 16'h0000;

  vpa_sync_cycle dut (
    .SYSCLK        (SYSCLK),
    .nRESET        (nRESET),
    .MCCLK_FALLING (MCCLK_FALLING),
    .ECLK          (ECLK),
    .nVPA          (nVPA),
    .START         (START),
    .IS_READ       (IS_READ),
    .D_IN          (D_IN),
    .RELEASE       (RELEASE),
    .ABORT         (ABORT),
    .VMA_DRIVE     (VMA_DRIVE),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .DATA_OUT      (DATA_OUT),
    .ECNT          (ECNT)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one SYSCLK; 7M strobe on every 4th cycle.
  task automatic tick();
    @(posedge SYSCLK);
    #1;
    cyc++;
    MCCLK_FALLING = ((cyc % 4) == 0);
  endtask

  // Expected ECNT during cycle c.
  function automatic int ecnt_at(input int c);
    int n;
    if (c <= p0) return e0;
    n = (c - 1 - p0) / 4 + 1;
    return (e0 + n) % 10;
  endfunction

  // First strobe cycle at or after c whose pre-increment phase equals k.
  function automatic int next_pulse(input int c, input int k);
    int n0;
    int v;
    n0 = (c <= p0) ? 0 : (c - p0 + 3) / 4;
    v  = (e0 + n0) % 10;
    return p0 + 4 * (n0 + ((k - v + 10) % 10));
  endfunction

  task automatic start_after(input int tgt, input int lead, output int s);
    repeat (3) tick();
    if (tgt >= 0) begin
      for (int i = 0; i < 40 && ecnt_at(cyc + 1) != tgt; i++) tick();
    end else begin
      repeat (lead) tick();
    end
    tick();
    s = cyc;
    START = 1'b1;
    chk("start_phase", ECNT, ecnt_at(s));
  endtask

  // Full nVPA cycle; without release it is left parked in HOLD.
  task automatic run_txn(input logic rd, input logic [15:0] din, input int tgt,
                         input int lead, input int rel_dly, input bit do_release);
    int s, p, q, r, h, stop, first_vma, ndone, done_cyc;
    logic busy_s1, vma_h, vma_h1, busy_h1;
    logic [15:0] data_obs;
    first_vma = -1; ndone = 0; done_cyc = -1;
    busy_s1 = 1'b0; vma_h = 1'b0; vma_h1 = 1'b1; busy_h1 = 1'b1;
    data_obs = 16'h0000;
    nVPA = 1'b0; IS_READ = rd; D_IN = ~din; RELEASE = 1'b0;
    start_after(tgt, lead, s);
    p = next_pulse(s + 2, 2);
    q = next_pulse(p + 1, 9);
    r = next_pulse(q + 2, 0);
    h = r + 1 + rel_dly;
    stop = do_release ? h + 1 : r + 3;
    for (int i = 0; i < 300 && cyc < stop; i++) begin
      tick();
      START   = 1'b0;
      IS_READ = ~rd;
      D_IN    = (cyc == q || cyc == q + 1) ? din : ~din;
      RELEASE = do_release && (cyc >= h);
      if (cyc == s + 1) busy_s1 = BUSY;
      if (VMA_DRIVE && first_vma < 0) first_vma = cyc;
      if (DONE) begin ndone++; done_cyc = cyc; end
      if (cyc == q + 2) data_obs = DATA_OUT;
      if (cyc == h) vma_h = VMA_DRIVE;
      if (cyc == h + 1) begin vma_h1 = VMA_DRIVE; busy_h1 = BUSY; end
    end
    if (rd) m_data = din;
    chk("busy_after_start", busy_s1, 1);
    chk("vma_rise_cycle", first_vma, p + 1);
    chk("done_count", ndone, 1);
    chk("done_cycle", done_cyc, r + 1);
    chk("data_out", data_obs, m_data);
    if (do_release) begin
      chk("vma_in_hold", vma_h, 1);
      chk("vma_after_release", vma_h1, 0);
      chk("busy_after_release", busy_h1, 0);
      RELEASE = 1'b0;
    end
  endtask

  task automatic dtack_txn(input int lead);
    int s;
    logic b1, b2, vma_any, done_any;
    b1 = 1'b0; b2 = 1'b1; vma_any = 1'b0; done_any = 1'b0;
    nVPA = 1'b1; IS_READ = 1'b1;
    start_after(-1, lead, s);
    for (int i = 0; i < 20 && cyc < s + 6; i++) begin
      tick();
      START = 1'b0;
      if (cyc == s + 1) b1 = BUSY;
      if (cyc == s + 2) b2 = BUSY;
      vma_any  = vma_any | VMA_DRIVE;
      done_any = done_any | DONE;
    end
    chk("dtack_busy_s1", b1, 1);
    chk("dtack_busy_s2", b2, 0);
    chk("dtack_vma", vma_any, 0);
    chk("dtack_done", done_any, 0);
    nVPA = 1'b0;
  endtask

  task automatic abort_txn(input int lead);
    int s, p, r;
    logic vma_p1, vma_p3, busy_p3, done_any;
    vma_p1 = 1'b0; vma_p3 = 1'b1; busy_p3 = 1'b1; done_any = 1'b0;
    nVPA = 1'b0; IS_READ = 1'b1; D_IN = 16'hDEAD;
    start_after(-1, lead, s);
    p = next_pulse(s + 2, 2);
    r = next_pulse(next_pulse(p + 1, 9) + 2, 0);
    for (int i = 0; i < 300 && cyc < r + 4; i++) begin
      tick();
      START = 1'b0;
      ABORT = (cyc == p + 2);
      if (cyc == p + 1) vma_p1 = VMA_DRIVE;
      if (cyc == p + 3) begin vma_p3 = VMA_DRIVE; busy_p3 = BUSY; end
      done_any = done_any | DONE;
    end
    ABORT = 1'b0;
    chk("abort_vma_before", vma_p1, 1);
    chk("abort_vma_after", vma_p3, 0);
    chk("abort_busy_after", busy_p3, 0);
    chk("abort_no_done", done_any, 0);
    chk("abort_data_kept", DATA_OUT, m_data);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vma"}, VMA_DRIVE, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_data"}, DATA_OUT, 0);
    chk({tag, "_ecnt"}, ECNT, 0);
  endtask

  initial begin
    int pa;
    nRESET = 1'b0; MCCLK_FALLING = 1'b0; ECLK = 1'b0; nVPA = 1'b1;
    START = 1'b0; IS_READ = 1'b0; D_IN = 16'h0000; RELEASE = 1'b0; ABORT = 1'b0;

    // Reset and release.
    repeat (3) tick();
    nRESET = 1'b1;
    p0 = ((cyc + 3) / 4) * 4; e0 = 0;
    tick();
    check_reset_outputs("reset");

    // Aligned read, late-start read, DTACK cycle.
    run_txn(1'b1, 16'hA5C3, 0, 0, 1, 1'b1);
    run_txn(1'b1, 16'h5A3C, 4, 0, 0, 1'b1);
    dtack_txn(2);

    // Write leaves previously read data untouched.
    run_txn(1'b1, 16'h1234, -1, 5, 2, 1'b1);
    run_txn(1'b0, 16'hBEEF, -1, 11, 3, 1'b1);

    // Abort while VMA is on, then a normal cycle.
    abort_txn(7);
    run_txn(1'b1, 16'h0F0F, -1, 3, 1, 1'b1);

    // ECLK rising while ecnt=3 forces ecnt to 6 on that strobe.
    pa = next_pulse(cyc + 1, 2);
    for (int i = 0; i < 60 && cyc < pa + 1; i++) tick();
    ECLK = 1'b1;
    for (int i = 0; i < 10 && cyc < pa + 4; i++) tick();
    chk("ecnt_before_resync", ECNT, 3);
    tick();
    chk("ecnt_resync", ECNT, 6);
    tick();
    ECLK = 1'b0;
    p0 = pa + 8; e0 = 6;
    for (int i = 0; i < 10 && cyc < pa + 9; i++) tick();
    chk("ecnt_after_resync", ECNT, ecnt_at(cyc));

    // Randomised mix of reads, writes and DTACK cycles.
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        dtack_txn(int'($urandom_range(0, 20)));
      end else begin
        run_txn(1'($urandom_range(0, 1)), 16'($urandom), -1,
                int'($urandom_range(0, 39)), int'($urandom_range(0, 5)), 1'b1);
      end
    end

    // Reset asserted while parked in HOLD clears all outputs asynchronously.
    run_txn(1'b1, 16'hC33C, -1, 6, 0, 1'b0);
    chk("hold_vma", VMA_DRIVE, 1);
    chk("hold_busy", BUSY, 1);
    #2;
    nRESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    tick();
    nRESET = 1'b1;
    p0 = ((cyc + 3) / 4) * 4; e0 = 0; m_data = 16'h0000;
    tick();
    chk("post_reset_ecnt", ECNT, ecnt_at(cyc));
    run_txn(1'b1, 16'h6789, -1, 9, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
